sa_cache_data: RTL and testbench

Parametrised set-associative cache data array: the successor of the direct-mapped line store. It holds `WAYS × SETS` cache lines and serves single-port read/write requests over a valid/ready handshake, with per-word write masking and a registered, back-pressurable read response. After reset it runs a hardware clear sequence so every line reads as zero. It sits between the cache controller (index/way from tag compare) and the line fill/writeback path.

---
 rtl/sa_cache_data.sv | 176 +++++++++++++++++
 tb/tb_sa_cache_data.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sa_cache_data.sv
// sa_cache_data: set-associative cache data array (WAYS x SETS lines of LINE_W).
// Single-port read/write over valid/ready, per-word write mask, registered
// back-pressurable read response. After reset an INIT sequence clears every
// set in every way before requests are accepted.
// Optional feature: define SA_CACHE_DATA_PARITY_EN to store one even-parity
// bit per WORD_W word and report per-word mismatches on rsp_perr.
module sa_cache_data #(
  parameter int WAYS   = 4,
  parameter int SETS   = 256,
  parameter int LINE_W = 128,
  parameter int WORD_W = 32,
  localparam int WORDS = LINE_W / WORD_W,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [IDX_W-1:0]  req_index,
  input  logic [WAY_W-1:0]  req_way,
  input  logic [WORDS-1:0]  req_wmask,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [LINE_W-1:0] rsp_data,
  output logic [WORDS-1:0]  rsp_perr,
  output logic              init_busy
);

  // One extra counter bit keeps the terminal compare free of wrap aliasing.
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(SETS - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   init_cnt_r;
  logic [IDX_W-1:0]   init_idx_s;
  logic [WAY_W-1:0]   way_s;
  logic               req_acc_s;
  logic               wr_acc_s;
  logic               rd_acc_s;
  logic [LINE_W-1:0]  rd_line_s;
  logic [WORDS-1:0]   rd_perr_s;

  logic [LINE_W-1:0]  mem [WAYS][SETS];

`ifdef SA_CACHE_DATA_PARITY_EN
  logic [WORDS-1:0]   par_mem [WAYS][SETS];

  // Even parity of each WORD_W granule of a line.
  function automatic logic [WORDS-1:0] word_parity(input logic [LINE_W-1:0] line);
    logic [WORDS-1:0] p;
    for (int i = 0; i < WORDS; i++) begin
      p[i] = ^line[i*WORD_W +: WORD_W];
    end
    return p;
  endfunction
`endif

  // FSM state register and INIT set counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_INIT;
      init_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_INIT) begin
        init_cnt_r <= init_cnt_r + CNT_W'(1);
      end
    end
  end

  // Next state: leave INIT once the last set has been cleared.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (init_cnt_r == INIT_LAST) state_nxt_s = ST_RUN;
        else                         state_nxt_s = ST_INIT;
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // FSM outputs: busy flag and request readiness (free slot or draining).
  always_comb begin
    init_busy = 1'b1;
    req_ready = 1'b0;
    case (state_r)
      ST_INIT: begin
        init_busy = 1'b1;
        req_ready = 1'b0;
      end
      ST_RUN: begin
        init_busy = 1'b0;
        req_ready = !rsp_valid || rsp_ready;
      end
      default: begin
        init_busy = 1'b1;
        req_ready = 1'b0;
      end
    endcase
  end

  // Handshake decode, way select and array read port.
  always_comb begin
    init_idx_s = init_cnt_r[IDX_W-1:0];
    if (WAYS == 1) way_s = {WAY_W{1'b0}};
    else           way_s = req_way;
    req_acc_s = req_valid && req_ready;
    wr_acc_s  = req_acc_s && req_we;
    rd_acc_s  = req_acc_s && !req_we;
    rd_line_s = mem[way_s][req_index];
`ifdef SA_CACHE_DATA_PARITY_EN
    rd_perr_s = word_parity(rd_line_s) ^ par_mem[way_s][req_index];
`else
    rd_perr_s = {WORDS{1'b0}};
`endif
  end

  // Line storage: INIT clears one set in every way per cycle, else masked writes.
  always_ff @(posedge clk) begin
    if (state_r == ST_INIT) begin
      for (int w = 0; w < WAYS; w++) begin
        mem[w][init_idx_s] <= {LINE_W{1'b0}};
      end
    end else if (wr_acc_s) begin
      for (int i = 0; i < WORDS; i++) begin
        if (req_wmask[i]) begin
          mem[way_s][req_index][i*WORD_W +: WORD_W] <= req_wdata[i*WORD_W +: WORD_W];
        end
      end
    end
  end

`ifdef SA_CACHE_DATA_PARITY_EN
  // Parity storage: zero during INIT, recomputed only for written words.
  always_ff @(posedge clk) begin
    if (state_r == ST_INIT) begin
      for (int w = 0; w < WAYS; w++) begin
        par_mem[w][init_idx_s] <= {WORDS{1'b0}};
      end
    end else if (wr_acc_s) begin
      for (int i = 0; i < WORDS; i++) begin
        if (req_wmask[i]) begin
          par_mem[way_s][req_index][i] <= ^req_wdata[i*WORD_W +: WORD_W];
        end
      end
    end
  end
`endif

  // Response register: load on read accept, hold under back-pressure, drop when drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= {LINE_W{1'b0}};
      rsp_perr  <= {WORDS{1'b0}};
    end else if (rd_acc_s) begin
      rsp_valid <= 1'b1;
      rsp_data  <= rd_line_s;
      rsp_perr  <= rd_perr_s;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sa_cache_data.sv
// Self-checking bench for sa_cache_data (default parameters: 4 ways, 256 sets,
// 128-bit lines, 32-bit words). Expected lines come from a bench-side model of
// the array and are queued at read issue, popped when the response appears.
module tb_sa_cache_data;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [7:0]   req_index;
  logic [1:0]   req_way;
  logic [3:0]   req_wmask;
  logic [127:0] req_wdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_data;
  logic [3:0]   rsp_perr;
  logic         init_busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [127:0] model [4][256];
  logic [127:0] exp_q [$];
  logic [3:0]   expp_q [$];

  sa_cache_data dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_index (req_index),
    .req_way   (req_way),
    .req_wmask (req_wmask),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_perr  (rsp_perr),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  task automatic clear_model();
    for (int w = 0; w < 4; w++)
      for (int s = 0; s < 256; s++)
        model[w][s] = 128'h0;
    exp_q.delete();
    expp_q.delete();
  endtask

  // Drives one write for one cycle (caller ensures req_ready) and updates the model.
  task automatic do_write(input logic [1:0] way, input logic [7:0] idx,
                          input logic [3:0] mask, input logic [127:0] data);
    req_valid = 1'b1; req_we = 1'b1; req_way = way; req_index = idx;
    req_wmask = mask; req_wdata = data;
    for (int i = 0; i < 4; i++)
      if (mask[i]) model[way][idx][i*32 +: 32] = data[i*32 +: 32];
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Drives one read for one cycle and queues the expected response.
  task automatic do_read(input logic [1:0] way, input logic [7:0] idx, input logic [3:0] eperr);
    req_valid = 1'b1; req_we = 1'b0; req_way = way; req_index = idx;
    req_wmask = 4'h0; req_wdata = 128'h0;
    exp_q.push_back(model[way][idx]);
    expp_q.push_back(eperr);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    logic [127:0] e;
    logic [3:0] ep;
    clear_model();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_way = 2'd0; req_index = 8'd0;
    req_wmask = 4'h0; req_wdata = 128'h0; rsp_ready = 1'b1;
    #2;
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready got %b exp 0", req_ready); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_data !== 128'h0) $display("FAIL reset_rsp_data got %h exp 0", rsp_data); else pass_cnt++;
    total_cnt++; if (rsp_perr !== 4'h0) $display("FAIL reset_rsp_perr got %b exp 0", rsp_perr); else pass_cnt++;
    total_cnt++; if (init_busy !== 1'b1) $display("FAIL reset_init_busy got %b exp 1", init_busy); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    while (init_busy === 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
    total_cnt++; if (n !== 256) $display("FAIL init_len got %0d exp 256", n); else pass_cnt++;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL ready_after_init got %b exp 1", req_ready); else pass_cnt++;
    do_read(2'd3, 8'd255, 4'h0);
    total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL idle_read_valid got %b exp 1", rsp_valid); else pass_cnt++;
    e = exp_q.pop_front(); ep = expp_q.pop_front();
    total_cnt++; if (rsp_data !== e) $display("FAIL idle_read_data got %h exp %h", rsp_data, e); else pass_cnt++;
    total_cnt++; if (rsp_perr !== ep) $display("FAIL idle_read_perr got %b exp %b", rsp_perr, ep); else pass_cnt++;
  endtask

  task automatic test_masked_write();
    logic [127:0] e;
    logic [127:0] lit;
    lit = 128'h00000000_33333333_00000000_11111111;
    do_write(2'd1, 8'd7, 4'b0101, 128'h44444444_33333333_22222222_11111111);
    do_read(2'd1, 8'd7, 4'h0);
    total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL mask_read_valid got %b exp 1", rsp_valid); else pass_cnt++;
    e = exp_q.pop_front(); void'(expp_q.pop_front());
    total_cnt++; if (rsp_data !== e) $display("FAIL mask_model got %h exp %h", rsp_data, e); else pass_cnt++;
    total_cnt++; if (rsp_data !== lit) $display("FAIL mask_words got %h exp %h", rsp_data, lit); else pass_cnt++;
    do_read(2'd0, 8'd7, 4'h0);
    e = exp_q.pop_front(); void'(expp_q.pop_front());
    total_cnt++; if (rsp_valid !== 1'b1 || rsp_data !== e) $display("FAIL other_way got v=%b %h exp v=1 %h", rsp_valid, rsp_data, e); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL mask_drain got %b exp 0", rsp_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [127:0] e;
    for (int k = 0; k < 4; k++)
      do_write(2'd2, 8'(10 + k), 4'hF, {$urandom(), $urandom(), $urandom(), $urandom()});
    for (int k = 0; k < 4; k++) begin
      total_cnt++; if (req_ready !== 1'b1) $display("FAIL b2b_ready[%0d] got %b exp 1", k, req_ready); else pass_cnt++;
      do_read(2'd2, 8'(10 + k), 4'h0);
      e = exp_q.pop_front(); void'(expp_q.pop_front());
      total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL b2b_valid[%0d] got %b exp 1", k, rsp_valid); else pass_cnt++;
      total_cnt++; if (rsp_data !== e) $display("FAIL b2b_data[%0d] got %h exp %h", k, rsp_data, e); else pass_cnt++;
    end
    @(posedge clk); #1;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL b2b_drain got %b exp 0", rsp_valid); else pass_cnt++;
  endtask

  task automatic test_random_rw();
    logic [127:0] e;
    logic [1:0] w;
    logic [7:0] s;
    for (int it = 0; it < 24; it++) begin
      w = 2'($urandom_range(3, 0));
      s = 8'($urandom_range(23, 20));
      if ($urandom_range(1, 0) == 1) begin
        do_write(w, s, 4'($urandom_range(15, 0)), {$urandom(), $urandom(), $urandom(), $urandom()});
      end else begin
        do_read(w, s, 4'h0);
        e = exp_q.pop_front(); void'(expp_q.pop_front());
        total_cnt++; if (rsp_valid !== 1'b1 || rsp_data !== e) $display("FAIL rand_read[%0d] got v=%b %h exp %h", it, rsp_valid, rsp_data, e); else pass_cnt++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] e;
    rsp_ready = 1'b0;
    do_read(2'd1, 8'd7, 4'h0);
    e = exp_q.pop_front(); void'(expp_q.pop_front());
    req_valid = 1'b1; req_we = 1'b1; req_way = 2'd1; req_index = 8'd7;
    req_wmask = 4'hF; req_wdata = {4{32'hFFFF_FFFF}};
    for (int c = 0; c < 5; c++) begin
      total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL bp_valid[%0d] got %b exp 1", c, rsp_valid); else pass_cnt++;
      total_cnt++; if (req_ready !== 1'b0) $display("FAIL bp_ready[%0d] got %b exp 0", c, req_ready); else pass_cnt++;
      total_cnt++; if (rsp_data !== e) $display("FAIL bp_hold[%0d] got %h exp %h", c, rsp_data, e); else pass_cnt++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL bp_release_ready got %b exp 1", req_ready); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL bp_drain got %b exp 0", rsp_valid); else pass_cnt++;
    do_read(2'd1, 8'd7, 4'h0);
    e = exp_q.pop_front(); void'(expp_q.pop_front());
    total_cnt++; if (rsp_data !== e) $display("FAIL bp_no_write got %h exp %h", rsp_data, e); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int n;
    logic [127:0] e;
    do_write(2'd0, 8'd3, 4'hF, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D);
    rsp_ready = 1'b0;
    do_read(2'd0, 8'd3, 4'h0);
    e = exp_q.pop_front(); void'(expp_q.pop_front());
    total_cnt++; if (rsp_valid !== 1'b1 || rsp_data !== e) $display("FAIL mr_pre got v=%b %h exp %h", rsp_valid, rsp_data, e); else pass_cnt++;
    #2; rst_n = 1'b0; #1;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL mr_async_valid got %b exp 0", rsp_valid); else pass_cnt++;
    total_cnt++; if (init_busy !== 1'b1) $display("FAIL mr_busy got %b exp 1", init_busy); else pass_cnt++;
    clear_model();
    @(negedge clk); rst_n = 1'b1; rsp_ready = 1'b1;
    n = 0;
    while (init_busy === 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
    total_cnt++; if (n !== 256) $display("FAIL mr_init_len got %0d exp 256", n); else pass_cnt++;
    do_read(2'd0, 8'd3, 4'h0);
    e = exp_q.pop_front(); void'(expp_q.pop_front());
    total_cnt++; if (rsp_valid !== 1'b1 || rsp_data !== e) $display("FAIL mr_cleared got v=%b %h exp %h", rsp_valid, rsp_data, e); else pass_cnt++;
  endtask

  task automatic test_parity();
    logic [127:0] e;
    logic [3:0] ep;
    do_write(2'd2, 8'd40, 4'hF, 128'h1357_9BDF_2468_ACE0_0F0F_F0F0_A5A5_5A5A);
`ifdef SA_CACHE_DATA_PARITY_EN
    dut.mem[2][40][64] = ~dut.mem[2][40][64];
    model[2][40][64] = ~model[2][40][64];
    do_read(2'd2, 8'd40, 4'b0100);
`else
    do_read(2'd2, 8'd40, 4'b0000);
`endif
    e = exp_q.pop_front(); ep = expp_q.pop_front();
    total_cnt++; if (rsp_data !== e) $display("FAIL par_data got %h exp %h", rsp_data, e); else pass_cnt++;
    total_cnt++; if (rsp_perr !== ep) $display("FAIL par_perr got %b exp %b", rsp_perr, ep); else pass_cnt++;
    do_read(2'd2, 8'd10, 4'h0);
    e = exp_q.pop_front(); ep = expp_q.pop_front();
    total_cnt++; if (rsp_perr !== ep || rsp_data !== e) $display("FAIL par_clean got %b %h exp %b %h", rsp_perr, rsp_data, ep, e); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_masked_write();
    test_back_to_back();
    test_random_rw();
    test_backpressure();
    test_mid_reset();
    test_parity();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
